// File: rtl/patp_mem_interface.sv
// PATP memory bridge: turns CU read/write strobes into a mem_req/mem_ack handshake and stalls the CU meanwhile.
// Optional REQ watchdog with sticky err flag is built in when MEM_TIMEOUT_EN is defined.
module patp_mem_interface #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              oe_ms,
    output logic [DATA_W-1:0] ms_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              strobe;

    assign strobe = read | write;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             err_reg;

    assign wait_cnt_next = wait_cnt_reg + 1'b1;
    assign err           = err_reg;
`else
    // TIMEOUT is only meaningful when the watchdog is compiled in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rdata_reg     <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_reg  <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (strobe) begin
                        mem_addr_reg  <= addr;
                        mem_wdata_reg <= wdata;
                        mem_we_reg    <= write;  // write wins when both strobes are high
                        mem_req_reg   <= 1'b1;
                        state_reg     <= REQ;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt_reg  <= '0;
`endif
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!mem_we_reg) begin
                            rdata_reg <= mem_rdata;
                        end
                        mem_req_reg <= 1'b0;
                        state_reg   <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt_next == CNT_W'(TIMEOUT)) begin
                        if (!mem_we_reg) begin
                            rdata_reg <= '1;
                        end
                        err_reg     <= 1'b1;
                        mem_req_reg <= 1'b0;
                        state_reg   <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                    end
`endif
                end
                DONE: begin
                    // Hold here until the CU drops its strobe so it cannot retrigger.
                    if (!strobe) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign ms_data   = oe_ms ? rdata_reg : '0;
    assign stall     = ((state_reg == IDLE) && strobe) || (state_reg == REQ);

endmodule

// File: tb/tb_patp_mem_interface.sv
// Self-checking bench for patp_mem_interface: directed scenarios plus randomized accesses
// checked against a transaction-level memory model.
module tb_patp_mem_interface;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          read, write, oe_ms, mem_ack;
    logic [AW-1:0] addr, mem_addr;
    logic [DW-1:0] wdata, ms_data, mem_wdata, mem_rdata;
    logic          stall, mem_req, mem_we, err;

    int checks = 0;
    int passes = 0;

    // mem: the bench's memory responder; exp_mem/exp_rdata: what the CU should see.
    logic [DW-1:0] mem     [0:31];
    logic [DW-1:0] exp_mem [0:31];
    logic [DW-1:0] exp_rdata;

    always #5 clk = ~clk;

    patp_mem_interface #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .wdata(wdata),
        .oe_ms(oe_ms), .ms_data(ms_data), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err)
    );

    // Transaction-level expectation: writes update the array, reads expose the stored word.
    task automatic model_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] d);
        if (wr) exp_mem[a] = d;
        else if (rd) exp_rdata = exp_mem[a];
    endtask

    // Runs one access from IDLE (called at a negedge) and reports what was observed.
    task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int waits, input int hold,
                             output int stall_cyc, output int req_cyc, output int extra_req,
                             output logic we_obs, output logic [AW-1:0] addr_obs,
                             output logic [DW-1:0] wdata_obs, output bit stable, output bit hung);
        int n;
        stall_cyc = 0; req_cyc = 0; extra_req = 0; stable = 1'b1; hung = 1'b0;
        we_obs = 1'bx; addr_obs = 'x; wdata_obs = 'x;
        read = rd; write = wr; addr = a; wdata = d;
        #1;
        if (stall === 1'b1) stall_cyc++;
        @(posedge clk); @(negedge clk);
        addr = AW'($urandom); wdata = DW'($urandom);
        #1;
        n = 0;
        while (mem_req === 1'b1) begin
            if (n == 0) begin
                we_obs = mem_we; addr_obs = mem_addr; wdata_obs = mem_wdata;
            end else if (mem_we !== we_obs || mem_addr !== addr_obs || mem_wdata !== wdata_obs) begin
                stable = 1'b0;
            end
            if (stall === 1'b1) stall_cyc++;
            req_cyc++;
            mem_ack   = (n == waits);
            mem_rdata = (n == waits && mem_we === 1'b0) ? mem[mem_addr] : DW'($urandom);
            @(posedge clk);
            if (mem_ack && mem_we === 1'b1) mem[mem_addr] = mem_wdata;
            @(negedge clk);
            mem_ack = 1'b0;
            addr = AW'($urandom); wdata = DW'($urandom);
            #1;
            n++;
            if (n >= 200) begin
                hung = 1'b1;
                rst = 1'b0; #1; rst = 1'b1;
                break;
            end
        end
        for (int h = 0; h < hold; h++) begin
            if (stall === 1'b1) stall_cyc++;
            if (mem_req === 1'b1) extra_req++;
            @(posedge clk); @(negedge clk); #1;
        end
        read = 1'b0; write = 1'b0;
        #1;
        if (stall === 1'b1) stall_cyc++;
        if (mem_req === 1'b1) extra_req++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        read = 1'b1; oe_ms = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL rst_stall_strobe got %b exp 1", stall); else passes++;
        checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %b exp 0", mem_req); else passes++;
        checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %b exp 0", mem_we); else passes++;
        checks++; if (mem_addr !== '0) $display("FAIL rst_mem_addr got %h exp 0", mem_addr); else passes++;
        checks++; if (mem_wdata !== '0) $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); else passes++;
        checks++; if (ms_data !== '0) $display("FAIL rst_ms_data got %h exp 0", ms_data); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else passes++;
        @(posedge clk); @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) $display("FAIL rst_held_req got %b exp 0", mem_req); else passes++;
        read = 1'b0; oe_ms = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL rst_stall_idle got %b exp 0", stall); else passes++;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        exp_rdata = '0;
    endtask

    task automatic test_read_zero_wait();
        int sc, rc, xr; logic we_o; logic [AW-1:0] a_o; logic [DW-1:0] d_o; bit st, hg;
        mem[5'h0A] = 8'h3C; exp_mem[5'h0A] = 8'h3C;
        do_access(1'b1, 1'b0, 5'h0A, 8'h00, 0, 0, sc, rc, xr, we_o, a_o, d_o, st, hg);
        model_access(1'b1, 1'b0, 5'h0A, 8'h00);
        checks++; if (hg) $display("FAIL rd0_hung req never dropped"); else passes++;
        checks++; if (sc !== 2) $display("FAIL rd0_stall_cycles got %0d exp 2", sc); else passes++;
        checks++; if (rc !== 1) $display("FAIL rd0_req_cycles got %0d exp 1", rc); else passes++;
        checks++; if (we_o !== 1'b0 || a_o !== 5'h0A) $display("FAIL rd0_we_addr got %b/%h exp 0/0a", we_o, a_o); else passes++;
        oe_ms = 1'b0; #1;
        checks++; if (ms_data !== 8'h00) $display("FAIL rd0_ms_off got %h exp 00", ms_data); else passes++;
        oe_ms = 1'b1; #1;
        checks++; if (ms_data !== exp_rdata) $display("FAIL rd0_ms_on got %h exp %h", ms_data, exp_rdata); else passes++;
        oe_ms = 1'b0;
    endtask

    task automatic test_write_wait();
        int sc, rc, xr; logic we_o; logic [AW-1:0] a_o; logic [DW-1:0] d_o; bit st, hg;
        do_access(1'b0, 1'b1, 5'h1F, 8'hA5, 3, 0, sc, rc, xr, we_o, a_o, d_o, st, hg);
        model_access(1'b0, 1'b1, 5'h1F, 8'hA5);
        checks++; if (hg) $display("FAIL wr3_hung req never dropped"); else passes++;
        checks++; if (rc !== 4) $display("FAIL wr3_req_cycles got %0d exp 4", rc); else passes++;
        checks++; if (sc !== 5) $display("FAIL wr3_stall_cycles got %0d exp 5", sc); else passes++;
        checks++; if (we_o !== 1'b1 || a_o !== 5'h1F || d_o !== 8'hA5)
            $display("FAIL wr3_latched got we=%b a=%h d=%h exp 1/1f/a5", we_o, a_o, d_o); else passes++;
        checks++; if (!st) $display("FAIL wr3_stable got unstable exp stable"); else passes++;
        checks++; if (mem[5'h1F] !== 8'hA5) $display("FAIL wr3_mem got %h exp a5", mem[5'h1F]); else passes++;
        oe_ms = 1'b1; #1;
        checks++; if (ms_data !== exp_rdata) $display("FAIL wr3_rdata_kept got %h exp %h", ms_data, exp_rdata); else passes++;
        oe_ms = 1'b0;
    endtask

    task automatic test_held_strobe();
        int sc, rc, xr; logic we_o; logic [AW-1:0] a_o; logic [DW-1:0] d_o; bit st, hg;
        do_access(1'b1, 1'b0, 5'h1F, 8'h00, 1, 3, sc, rc, xr, we_o, a_o, d_o, st, hg);
        model_access(1'b1, 1'b0, 5'h1F, 8'h00);
        checks++; if (rc !== 2) $display("FAIL hold_req_cycles got %0d exp 2", rc); else passes++;
        checks++; if (xr !== 0) $display("FAIL hold_retrigger got %0d extra req cycles exp 0", xr); else passes++;
        checks++; if (sc !== 3) $display("FAIL hold_stall_cycles got %0d exp 3", sc); else passes++;
        oe_ms = 1'b1; #1;
        checks++; if (ms_data !== exp_rdata) $display("FAIL hold_rdata got %h exp %h", ms_data, exp_rdata); else passes++;
        oe_ms = 1'b0;
        do_access(1'b1, 1'b0, 5'h0A, 8'h00, 0, 0, sc, rc, xr, we_o, a_o, d_o, st, hg);
        model_access(1'b1, 1'b0, 5'h0A, 8'h00);
        checks++; if (rc !== 1 || a_o !== 5'h0A) $display("FAIL hold_next_access got req=%0d a=%h exp 1/0a", rc, a_o); else passes++;
    endtask

    task automatic test_both_strobes();
        int sc, rc, xr; logic we_o; logic [AW-1:0] a_o; logic [DW-1:0] d_o; bit st, hg;
        do_access(1'b1, 1'b1, 5'h03, 8'h5A, 0, 0, sc, rc, xr, we_o, a_o, d_o, st, hg);
        model_access(1'b1, 1'b1, 5'h03, 8'h5A);
        checks++; if (we_o !== 1'b1) $display("FAIL both_we got %b exp 1", we_o); else passes++;
        checks++; if (mem[5'h03] !== 8'h5A) $display("FAIL both_mem got %h exp 5a", mem[5'h03]); else passes++;
        oe_ms = 1'b1; #1;
        checks++; if (ms_data !== exp_rdata) $display("FAIL both_rdata got %h exp %h", ms_data, exp_rdata); else passes++;
        oe_ms = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        read = 1'b1; addr = 5'h07;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1) $display("FAIL rstreq_pending got %b exp 1", mem_req); else passes++;
        rst = 1'b0; oe_ms = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) $display("FAIL rstreq_drop got %b exp 0", mem_req); else passes++;
        exp_rdata = '0;
        read = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 8'h77;
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++; if (ms_data !== exp_rdata) $display("FAIL rstreq_rdata got %h exp %h", ms_data, exp_rdata); else passes++;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL rstreq_idle got req=%b stall=%b exp 0/0", mem_req, stall); else passes++;
        oe_ms = 1'b0;
    endtask

    task automatic test_random();
        int sc, rc, xr, waits, hold; logic we_o; logic [AW-1:0] a_o; logic [DW-1:0] d_o; bit st, hg;
        logic rd, wr; logic [AW-1:0] a; logic [DW-1:0] d;
        for (int t = 0; t < 24; t++) begin
            rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            a = AW'($urandom); d = DW'($urandom);
            waits = $urandom_range(0, 4); hold = $urandom_range(0, 2);
            do_access(rd, wr, a, d, waits, hold, sc, rc, xr, we_o, a_o, d_o, st, hg);
            model_access(rd, wr, a, d);
            oe_ms = 1'b1; #1;
            checks++;
            if (hg || sc !== waits + 2 || rc !== waits + 1 || xr !== 0 || !st || we_o !== wr ||
                a_o !== a || (wr && d_o !== d) || ms_data !== exp_rdata)
                $display("FAIL rand_%0d got stall=%0d req=%0d extra=%0d stable=%0d we=%b a=%h d=%h ms=%h exp stall=%0d req=%0d extra=0 stable=1 we=%b a=%h d=%h ms=%h",
                         t, sc, rc, xr, st, we_o, a_o, d_o, ms_data, waits + 2, waits + 1, wr, a, d, exp_rdata);
            else passes++;
            oe_ms = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            checks++; if (mem[i] !== exp_mem[i]) $display("FAIL rand_mem_%0d got %h exp %h", i, mem[i], exp_mem[i]); else passes++;
        end
`ifndef MEM_TIMEOUT_EN
        checks++; if (err !== 1'b0) $display("FAIL rand_err got %b exp 0", err); else passes++;
`endif
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int sc, rc, xr; logic we_o; logic [AW-1:0] a_o; logic [DW-1:0] d_o; bit st, hg;
        do_access(1'b1, 1'b0, 5'h11, 8'h00, 1000, 0, sc, rc, xr, we_o, a_o, d_o, st, hg);
        exp_rdata = 8'hFF;
        checks++; if (rc !== TO) $display("FAIL to_req_cycles got %0d exp %0d", rc, TO); else passes++;
        checks++; if (sc !== TO + 1) $display("FAIL to_stall_cycles got %0d exp %0d", sc, TO + 1); else passes++;
        oe_ms = 1'b1; #1;
        checks++; if (ms_data !== exp_rdata) $display("FAIL to_rdata got %h exp %h", ms_data, exp_rdata); else passes++;
        checks++; if (err !== 1'b1) $display("FAIL to_err got %b exp 1", err); else passes++;
        oe_ms = 1'b0;
        do_access(1'b0, 1'b1, 5'h12, 8'h42, 2, 0, sc, rc, xr, we_o, a_o, d_o, st, hg);
        model_access(1'b0, 1'b1, 5'h12, 8'h42);
        checks++; if (err !== 1'b1) $display("FAIL to_err_sticky got %b exp 1", err); else passes++;
        rst = 1'b0; #1;
        checks++; if (err !== 1'b0) $display("FAIL to_err_reset got %b exp 0", err); else passes++;
        @(negedge clk); rst = 1'b1; exp_rdata = '0;
        @(posedge clk); @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b0; read = 1'b0; write = 1'b0; oe_ms = 1'b0; mem_ack = 1'b0;
        addr = '0; wdata = '0; mem_rdata = '0; exp_rdata = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = DW'($urandom);
            exp_mem[i] = mem[i];
        end
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_held_strobe();
        test_both_strobes();
        test_reset_mid_req();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
